// File: rtl/adder_collector.sv
// Collects NUM operand words into one group for a multi-input adder; flush via ADDER_COLLECTOR_FLUSH_EN.
// Latency: out_valid rises the cycle after the NUM-th accept; one dead input cycle on HOLD exit.
// Backpressure: in_ready drops while a group is held; the group stays stable until out_ready.
module adder_collector #(
  parameter int BITS = 8,
  parameter int NUM  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [BITS-1:0]     in_data,
  output logic                in_ready,
  input  logic                out_ready,
`ifdef ADDER_COLLECTOR_FLUSH_EN
  input  logic                flush,
`endif
  output logic                out_valid,
  output logic [NUM*BITS-1:0] data_out,
  output logic [NUM-1:0]      lane_mask
);

  localparam int CW = $clog2(NUM) + 1;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM*BITS-1:0] data_q, data_d;
  logic [NUM-1:0]      mask_q, mask_d;
  logic                accept;
  logic                last;
  logic                flush_go;

  assign in_ready = (state_q == COLLECT) && !rst;
  assign accept   = in_valid && in_ready;
  assign last     = (cnt_q == CW'(NUM - 1));

`ifdef ADDER_COLLECTOR_FLUSH_EN
  // A flush only closes a group that holds, or is about to hold, at least one word.
  assign flush_go = flush && (state_q == COLLECT) && ((cnt_q != '0) || accept);
`else
  assign flush_go = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    mask_d  = mask_q;
    case (state_q)
      COLLECT: begin
        for (int k = 0; k < NUM; k++) begin
          if (accept && (cnt_q == CW'(k))) begin
            data_d[k*BITS +: BITS] = in_data;
            mask_d[k]              = 1'b1;
          end
        end
        if (accept) begin
          cnt_d = last ? '0 : cnt_q + CW'(1);
        end
        if ((accept && last) || flush_go) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = COLLECT;
          data_d  = '0;
          mask_d  = '0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      data_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign data_out  = data_q;
  assign lane_mask = mask_q;

endmodule

// File: tb/tb_adder_collector.sv
// Bench for adder_collector: directed steps plus random traffic against a queue-based group model.
module tb_adder_collector;
  localparam int BITS = 8;
  localparam int NUM  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic [BITS-1:0]     in_data;
  logic                in_ready;
  logic                out_ready;
  logic                flush;
  logic                out_valid;
  logic [NUM*BITS-1:0] data_out;
  logic [NUM-1:0]      lane_mask;

  int errors = 0;
  int checks = 0;

  // Reference: words collected so far, and whether a finished group is being offered.
  logic [BITS-1:0] mq[$];
  bit              mhold;

  adder_collector #(.BITS(BITS), .NUM(NUM)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_ready (out_ready),
`ifdef ADDER_COLLECTOR_FLUSH_EN
    .flush     (flush),
`endif
    .out_valid (out_valid),
    .data_out  (data_out),
    .lane_mask (lane_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM*BITS-1:0] model_data();
    logic [NUM*BITS-1:0] pk = '0;
    for (int i = 0; i < mq.size(); i++) pk[i*BITS +: BITS] = mq[i];
    return pk;
  endfunction

  function automatic logic [NUM-1:0] model_mask();
    logic [NUM-1:0] m = '0;
    for (int i = 0; i < mq.size(); i++) m[i] = 1'b1;
    return m;
  endfunction

  // One clock: apply inputs, check ready, advance model on the edge, check outputs after it.
  task automatic cycle(input logic v, input logic [BITS-1:0] d, input logic r,
                       input logic rs, input logic f, input string tag);
    bit acc;
    bit fl;
    rst = rs; in_valid = v; in_data = d; out_ready = r; flush = f;
    #1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'(!rs && !mhold));
    @(posedge clk);
    acc = !rs && !mhold && v;
`ifdef ADDER_COLLECTOR_FLUSH_EN
    fl = !rs && !mhold && f && (mq.size() > 0 || acc);
`else
    fl = 1'b0;
`endif
    if (rs) begin
      mq.delete();
      mhold = 1'b0;
    end else if (mhold) begin
      if (r) begin
        mq.delete();
        mhold = 1'b0;
      end
    end else begin
      if (acc) mq.push_back(d);
      if (mq.size() == NUM || fl) mhold = 1'b1;
    end
    #1;
    check({tag, "_out_valid"}, 32'(out_valid), 32'(mhold));
    check({tag, "_data_out"},  32'(data_out),  32'(model_data()));
    check({tag, "_lane_mask"}, 32'(lane_mask), 32'(model_mask()));
  endtask

  initial begin
    mhold = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    cycle(0, 8'h00, 0, 1, 0, "reset0");
    cycle(1, 8'h5C, 1, 1, 0, "reset1");
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_lane_mask", 32'(lane_mask), 32'd0);

    // Basic group with no backpressure.
    cycle(1, 8'h11, 1, 0, 0, "g1_w0");
    cycle(1, 8'h22, 1, 0, 0, "g1_w1");
    check("g1_valid", 32'(out_valid), 32'd1);
    check("g1_data",  32'(data_out),  32'h2211);
    check("g1_mask",  32'(lane_mask), 32'h3);
    cycle(0, 8'h00, 1, 0, 0, "g1_exit");
    check("g1_one_cycle", 32'(out_valid), 32'd0);

    // Held group under backpressure; in_valid pulses must be ignored.
    cycle(1, 8'h33, 0, 0, 0, "g2_w0");
    cycle(1, 8'h44, 0, 0, 0, "g2_w1");
    for (int i = 0; i < 5; i++) begin
      cycle(i[0], 8'hE0 + 8'(i), 0, 0, 0, "g2_hold");
      check("g2_hold_data", 32'(data_out), 32'h4433);
    end
    cycle(0, 8'h00, 1, 0, 0, "g2_exit");

    // Continuous stream 1..4; word 3 is held upstream during the HOLD-exit cycle.
    cycle(1, 8'h01, 1, 0, 0, "g3_w0");
    cycle(1, 8'h02, 1, 0, 0, "g3_w1");
    check("g3_data", 32'(data_out), 32'h0201);
    cycle(1, 8'h03, 1, 0, 0, "g3_gap");
    cycle(1, 8'h03, 1, 0, 0, "g4_w0");
    cycle(1, 8'h04, 1, 0, 0, "g4_w1");
    check("g4_data", 32'(data_out), 32'h0403);
    cycle(0, 8'h00, 1, 0, 0, "g4_exit");

    // Reset mid-group discards the partial word.
    cycle(1, 8'h99, 1, 0, 0, "g5_pre");
    cycle(0, 8'h00, 1, 1, 0, "g5_rst");
    cycle(1, 8'hAA, 1, 0, 0, "g5_w0");
    cycle(1, 8'hBB, 1, 0, 0, "g5_w1");
    check("g5_data", 32'(data_out), 32'hBBAA);
    cycle(0, 8'h00, 1, 0, 0, "g5_exit");

`ifdef ADDER_COLLECTOR_FLUSH_EN
    cycle(1, 8'h5A, 1, 0, 0, "f1_w0");
    cycle(0, 8'h00, 0, 0, 1, "f1_flush");
    check("f1_data", 32'(data_out),  32'h005A);
    check("f1_mask", 32'(lane_mask), 32'h1);
    cycle(0, 8'h00, 1, 0, 0, "f1_exit");
    cycle(0, 8'h00, 1, 0, 1, "f2_empty");
    check("f2_no_valid", 32'(out_valid), 32'd0);
    cycle(1, 8'h66, 1, 0, 0, "f3_w0");
    cycle(1, 8'h77, 0, 0, 1, "f3_w1");
    check("f3_data", 32'(data_out),  32'h7766);
    check("f3_mask", 32'(lane_mask), 32'h3);
    cycle(0, 8'h00, 1, 0, 0, "f3_exit");
`endif

    // Random traffic, including occasional resets and flushes.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 7) == 0), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adder_collector.md
ADDER_COLLECTOR -- requirements
Module: adder_collector

Interface
REQ-001 SHALL have parameter BITS, default 8, width of one operand word.
REQ-002 SHALL have parameter NUM, default 2, range 2..16, operands per group.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 SHALL have port in_valid  input  1  upstream word valid.
REQ-006 SHALL have port in_data  input  BITS  upstream operand word.
REQ-007 SHALL have port in_ready  output  1  collector accepts a word this cycle.
REQ-008 SHALL have port out_ready  input  1  downstream accepts the group; tie high when the downstream adder has no backpressure.
REQ-009 SHALL have port out_valid  output  1  group valid; drives the adder valid input.
REQ-010 SHALL have port data_out  output  NUM*BITS  lane k at bits [k*BITS +: BITS]; feeds adder operand input data_in<k>.
REQ-011 SHALL have port lane_mask  output  NUM  bit k set means lane k holds a collected word.
REQ-012 SHALL have port flush  input  1  emit a partial group; present only when the macro is defined (REQ-031).

Function
REQ-013 SHALL implement exactly two states: COLLECT and HOLD.
REQ-014 In COLLECT, in_ready SHALL be 1 and out_valid SHALL be 0; in HOLD, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-015 A word SHALL be accepted only when in_valid and in_ready are both 1.
REQ-016 An accepted word SHALL be written to lane cnt; cnt SHALL then increment and lane_mask[cnt] SHALL be set.
REQ-017 Internal counter cnt SHALL be clog2(NUM)+1 bits wide, count 0..NUM-1, and never wrap past NUM-1.
REQ-018 An accept with cnt==NUM-1 SHALL move the block to HOLD on the next edge, with cnt cleared to 0.
REQ-019 out_valid SHALL rise in the cycle after the NUM-th accept (latency 1).
REQ-020 In HOLD, data_out and lane_mask SHALL stay stable until out_ready is sampled as 1.
REQ-021 When HOLD and out_ready are both 1, the block SHALL go to COLLECT on the next edge and clear all lanes and lane_mask to 0.
REQ-022 The block SHALL accept no words in the HOLD-exit cycle; minimum group period is NUM+1 cycles.
REQ-023 in_valid while in_ready is 0 SHALL be ignored; upstream holds the word.
REQ-024 in_data SHALL be registered unmodified; this block performs no arithmetic.
REQ-025 Without flush, lane_mask SHALL be all ones whenever out_valid is 1.

Reset
REQ-026 While rst is 1, the next edge SHALL force state COLLECT, cnt 0, all lanes 0, lane_mask 0, out_valid 0.
REQ-027 While rst is 1, in_ready SHALL be driven 0 combinationally.
REQ-028 rst SHALL take priority over every other input.
REQ-029 Reset in mid-group or in HOLD SHALL discard the partial or pending group without emitting it.
REQ-030 Reset SHALL NOT depend on any clock edge other than clk.

Configuration
REQ-031 Macro ADDER_COLLECTOR_FLUSH_EN SHALL compile in the flush port and the flush logic.
REQ-032 With the macro: flush=1 in COLLECT with cnt>0 SHALL move the block to HOLD with unfilled lanes 0 and lane_mask showing only the filled lanes.
REQ-033 With the macro: flush and an accept in the same cycle SHALL include the accepted word in the emitted group.
REQ-034 With the macro: flush with cnt==0 and no accept SHALL be ignored.
REQ-035 With the macro: flush in HOLD SHALL be ignored.
REQ-036 Without the macro, the flush port SHALL NOT exist and behaviour SHALL be exactly REQ-013..REQ-025.

Verification (BITS=8, NUM=2)
REQ-037 Reset, then words 0x11 and 0x22 with out_ready=1 -> out_valid=1 for exactly one cycle, the cycle after 0x22; data_out=0x2211, lane_mask=2'b11.
REQ-038 Complete group with out_ready=0 for 5 cycles -> out_valid and data_out held for all 5 cycles; in_ready=0; in_valid pulses ignored.
REQ-039 Continuous in_valid with words 1,2,3,4 and out_ready=1 -> groups 0x0201 then 0x0403; in_ready low one cycle between groups.
REQ-040 rst=1 after one word accepted, then words 0xAA, 0xBB -> emitted group is 0xBBAA; the pre-reset word never appears.
REQ-041 With ADDER_COLLECTOR_FLUSH_EN: word 0x5A, then flush -> data_out=0x005A, lane_mask=2'b01; flush at cnt=0 -> no out_valid.
REQ-042 With ADDER_COLLECTOR_FLUSH_EN: flush in the same cycle as the second word 0x77 (first word 0x66) -> data_out=0x7766, lane_mask=2'b11.
